// File: rtl/wb_pdm_rx_channel.sv
// wb_pdm_rx_channel: PDM microphone receiver.
// It generates the mic clock, captures the 1-bit stream and decimates it with a
// 2nd-order CIC filter into unsigned PCM samples. The latest sample, with valid
// and overrun flags, is exposed as one read-only pipelined Wishbone register.
// Optional build macro WB_PDM_RX_IRQ_EN adds pdm_irq_o, which mirrors valid.
// wb_rst_i asserts asynchronously and is expected to be released synchronously
// to wb_clk_i.
module wb_pdm_rx_channel #(
   parameter int BIT_RESOLUTION = 12,
   parameter int DECIM_LOG2     = 6,
   parameter int CLK_DIV        = 16
) (
   input  logic                      wb_clk_i,
   input  logic                      wb_rst_i,
   input  logic                      wb_stb_i,
   output logic                      wb_ack_o,
   output logic [BIT_RESOLUTION+1:0] wb_dat_o,
   output logic                      pdm_clk_o,
   input  logic                      pdm_dat_i
`ifdef WB_PDM_RX_IRQ_EN
   ,
   output logic                      pdm_irq_o
`endif
);

   localparam int CW   = 2*DECIM_LOG2 + 1;
   localparam int PW   = 2*DECIM_LOG2;
   localparam int DIVW = $clog2(CLK_DIV);
   localparam logic [DIVW-1:0] DIV_LAST = DIVW'(CLK_DIV - 1);
   localparam logic [DIVW-1:0] DIV_HALF = DIVW'(CLK_DIV / 2);

   logic [DIVW-1:0]           r_divCount;
   logic [DIVW-1:0]           w_divNext;
   logic                      r_pdmClk;
   logic [1:0]                r_sync;
   logic                      w_pdmBit;
   logic                      w_strobe;
   logic [CW-1:0]             r_int1;
   logic [CW-1:0]             r_int2;
   logic [CW-1:0]             w_int1Next;
   logic [DECIM_LOG2-1:0]     r_phase;
   logic                      r_decim;
   logic [CW-1:0]             r_dly1;
   logic [CW-1:0]             r_dly2;
   logic [CW-1:0]             w_comb1;
   logic [CW-1:0]             w_combY;
   logic [PW-1:0]             w_sat;
   logic [BIT_RESOLUTION-1:0] w_newSample;
   logic [BIT_RESOLUTION-1:0] r_sample;
   logic                      r_valid;
   logic                      r_overrun;
   logic                      w_validNext;
   logic                      w_overrunNext;
   logic                      r_ack;
   logic [BIT_RESOLUTION+1:0] r_dat;

   // The mic clock is high for the first half of each divider period. It is
   // registered from the next divider value so that it lines up with the count.
   assign w_divNext = (r_divCount == DIV_LAST) ? '0 : r_divCount + 1'b1;

   // The capture strobe sits on the last cycle of the low phase, just before the
   // rising edge, so the bit launched on the falling edge has had half a period.
   assign w_strobe  = (r_divCount == DIV_LAST);
   assign w_pdmBit  = r_sync[1];

   // Divider counter and the registered mic clock.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         r_divCount <= '0;
         r_pdmClk   <= 1'b0;
      end else begin
         r_divCount <= w_divNext;
         r_pdmClk   <= (w_divNext < DIV_HALF);
      end
   end

   // Two-flop synchroniser for the mic data, which is asynchronous to wb_clk_i.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[0], pdm_dat_i};
      end
   end

   // Integrators wrap modulo 2**CW; the combs undo the wrap exactly because the
   // true output never exceeds R*R.
   assign w_int1Next = r_int1 + {{(CW-1){1'b0}}, w_pdmBit};

   // Integrator pair and decimation phase; the last bit of a window flags the
   // comb stage for the following cycle.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         r_int1  <= '0;
         r_int2  <= '0;
         r_phase <= '0;
         r_decim <= 1'b0;
      end else begin
         r_decim <= w_strobe && (r_phase == '1);
         if (w_strobe) begin
            r_int1  <= w_int1Next;
            r_int2  <= r_int2 + w_int1Next;
            r_phase <= r_phase + 1'b1;
         end
      end
   end

   // Comb differences. Only y == R*R reaches the top bit in steady state, so
   // that bit alone decides saturation.
   assign w_comb1     = r_int2 - r_dly1;
   assign w_combY     = w_comb1 - r_dly2;
   assign w_sat       = w_combY[CW-1] ? '1 : w_combY[PW-1:0];
   assign w_newSample = w_sat[PW-1 -: BIT_RESOLUTION];

   // Comb delay elements advance once per decimated output.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         r_dly1 <= '0;
         r_dly2 <= '0;
      end else if (r_decim) begin
         r_dly1 <= r_int2;
         r_dly2 <= w_comb1;
      end
   end

   // Flag update. A read in the same cycle as a sample write consumes the old
   // sample, so the new one arrives valid and without overrun.
   always_comb begin
      w_validNext   = r_valid;
      w_overrunNext = r_overrun;
      if (r_decim) begin
         w_validNext   = 1'b1;
         w_overrunNext = wb_stb_i ? 1'b0 : (r_overrun | r_valid);
      end else if (wb_stb_i) begin
         w_validNext   = 1'b0;
         w_overrunNext = 1'b0;
      end
   end

   // Sample register and its status flags.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         r_sample  <= '0;
         r_valid   <= 1'b0;
         r_overrun <= 1'b0;
      end else begin
         r_valid   <= w_validNext;
         r_overrun <= w_overrunNext;
         if (r_decim) begin
            r_sample <= w_newSample;
         end
      end
   end

   // Wishbone read port: the ack follows the strobe by one cycle and the data
   // snapshot is taken on the strobe cycle, then held until the next read.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         r_ack <= 1'b0;
         r_dat <= '0;
      end else begin
         r_ack <= wb_stb_i;
         if (wb_stb_i) begin
            r_dat <= {r_valid, r_overrun, r_sample};
         end
      end
   end

   assign wb_ack_o  = r_ack;
   assign wb_dat_o  = r_dat;
   assign pdm_clk_o = r_pdmClk;

`ifdef WB_PDM_RX_IRQ_EN
   logic r_irq;

   // Interrupt tracks valid cycle for cycle, so it is loaded from valid's next value.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         r_irq <= 1'b0;
      end else begin
         r_irq <= w_validNext;
      end
   end

   assign pdm_irq_o = r_irq;
`endif

endmodule

// File: doc/wb_pdm_rx_channel.md
Name: wb_pdm_rx_channel

Overview:
- PDM microphone receiver.
- Generates the mic clock, captures the 1-bit PDM stream, and decimates it with a 2nd-order CIC filter (ratio 2**DECIM_LOG2) into BIT_RESOLUTION-bit unsigned PCM samples.
- Latest sample plus valid/overrun flags are exposed as one read-only Wishbone B4 pipelined register.
- Counterpart to the PDM output channel: audio in rather than audio out.

Parameters:
- BIT_RESOLUTION, 12, PCM sample width; must be <= 2*DECIM_LOG2.
- DECIM_LOG2, 6, log2 of decimation ratio R; R = 64 by default.
- CLK_DIV, 16, wb_clk_i cycles per pdm_clk_o period; even, >= 4.

Ports:
- wb_clk_i  in  1  system clock; the only clock.
- wb_rst_i  in  1  reset, asynchronous, active-high.
- wb_stb_i  in  1  read strobe; one request per cycle.
- wb_ack_o  out  1  acknowledge.
- wb_dat_o  out  BIT_RESOLUTION+2  read data: [BR+1]=valid, [BR]=overrun, [BR-1:0]=sample.
- pdm_clk_o  out  1  clock to the microphone.
- pdm_dat_i  in  1  PDM data from the microphone; asynchronous to wb_clk_i.

Behaviour:
- Reset: asynchronous assertion and synchronous release. All registers clear to 0: divider, synchroniser, integrators, combs, sample, valid, overrun. pdm_clk_o=0, wb_ack_o=0, wb_dat_o=0. Reset mid-frame discards the partial decimation window.
- Clock divider:
  - Counter div runs 0..CLK_DIV-1 and wraps.
  - pdm_clk_o is registered: 1 while div < CLK_DIV/2, else 0.
- Input synchroniser: pdm_dat_i passes through a 2-flop synchroniser giving s.
- Capture strobe:
  - Fires when div == CLK_DIV-1, the last cycle of the low phase.
  - Captured bit x = s, value 0 or 1.
  - The mic launches data on the falling edge.
- CIC datapath:
  - W = 2*DECIM_LOG2+1 bits; all arithmetic modulo 2**W, and wrap-around is legal.
  - On each strobe: i1 <= i1 + x; i2 <= i2 + i1 + x (i2 uses the updated i1).
  - Phase counter ph (DECIM_LOG2 bits) increments on each strobe.
  - When the strobe occurs with ph == R-1, the decimation event is flagged for the next cycle.
- Comb stage, in the cycle after a decimation event:
  - c1 = i2 - d1; d1 <= i2.
  - y = c1 - d2; d2 <= c1.
  - y lies in 0..R*R.
- Output mapping:
  - Saturate y to 2**(2*DECIM_LOG2)-1.
  - Sample = the top BIT_RESOLUTION bits of that 2*DECIM_LOG2-bit value.
- Latency: sample and valid update exactly 2 wb_clk_i cycles after the strobe cycle of the R-th bit.
- Sample register: the last written sample holds until the next decimation. The first 2 samples after reset are a filter transient; their values are unspecified but must be deterministic.
- Flags:
  - A sample write sets valid=1.
  - If valid was already 1 and is not cleared by a read in that same cycle, overrun is set to 1.
- Wishbone read:
  - wb_ack_o is registered as wb_stb_i; 1-cycle latency; back-to-back strobes give back-to-back acks.
  - wb_dat_o is registered on the stb cycle: the current {valid, overrun, sample}.
  - The read clears valid and overrun at the same edge.
  - Simultaneous sample write and read: the read returns the old contents. The new sample loads with valid=1. Overrun is cleared, since the old sample was consumed.
  - wb_dat_o holds its value between acks.
- Write requests do not exist; the block has no we/cyc inputs.

Optional Feature:
- Macro WB_PDM_RX_IRQ_EN.
- When defined:
  - Adds output port pdm_irq_o (1 bit), registered.
  - pdm_irq_o equals valid: rises in the cycle valid sets and drops in the cycle after the clearing read's edge.
  - Reset value 0.
- When undefined: the port is absent and no logic is added; all other behaviour is identical.

Test Plan:
- Divider: after reset, pdm_clk_o is 1 for 8 and 0 for 8 wb_clk_i cycles, repeating. A strobe fires every 16 cycles with div=15.
- Constant 1: pdm_dat_i=1, defaults. After the 3rd sample, every read returns valid=1, overrun=0, sample=4095 (y=4096 saturated).
- Constant 0, then alternating: pdm_dat_i=0 gives sample=0. Alternating 1,0 per captured bit gives sample=2048 once settled (y=2048).
- Latency: measure from the strobe of bit 64 to valid rising. It must be exactly 2 cycles, with one sample per 1024 wb_clk_i cycles.
- Overrun and collision:
  - Skip reading for 2 sample periods; the read then returns valid=1, overrun=1, and the next read shows valid=0, overrun=0.
  - Read in the exact cycle a sample loads; it returns the old data, and the next read shows valid=1, overrun=0.
- Async reset: assert wb_rst_i mid-window between clock edges. Outputs go to 0 immediately. After release, the first valid appears after 64 strobes, and pdm_irq_o (if enabled) tracks valid.
